seq_chunk_adder: RTL and testbench

- Multi-cycle, parametrised successor to the combinational 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, LSB slice first, and carries between slices in a register.
- Valid/ready handshake on both sides, so it drops into the datapath between operand registers and the ALU result bus.
- Trades latency for a short carry chain.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/chunk_adder.sv | 39 +++
 rtl/seq_chunk_adder.sv | 165 ++++++++++++++++
 tb/tb_seq_chunk_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder.
// Contents: FSM state encoding, default operand/slice widths, and a
// constant clog2 helper used to size the slice counter.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 2;

  // Number of bits needed to count 0..n-1 (0 when n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice.
// Ports:
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the MSB
//   cmsb  : carry into the MSB (only with SEQ_CHUNK_ADDER_OVF_EN defined;
//           used for signed-overflow detection)
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  output logic             cmsb,
`endif
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign cmsb = c[CHUNK-1];
`endif

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB slice
// first, with the inter-slice carry held in a register. Valid/ready
// handshake on input and output.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid/in_ready   : operand handshake
//   x, y, c_in, sub     : operands, carry/borrow-in, 1 = subtract
//   out_valid/out_ready : result handshake
//   s, c_out            : result and carry-out (sub: 1 = no borrow)
//   ovf                 : signed overflow, present only when the macro
//                         SEQ_CHUNK_ADDER_OVF_EN is defined
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_chunk_adder: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
  logic               slice_cmsb;
`endif

  logic [CHUNK-1:0]   slice_sum;
  logic               slice_cout;

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (opa_q[CHUNK-1:0]),
    .b    (opb_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .cmsb (slice_cmsb),
`endif
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction as x + ~y + ~c_in: invert y here, invert c_in via sub.
          opa_d      = x;
          opb_d      = sub ? ~y : y;
          carry_d    = c_in ^ sub;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // New slice enters at the top; after NCHUNK steps the LSB slice has
        // reached bit 0. Shifting by WIDTH (CHUNK == WIDTH) yields zero.
        s_d     = (s_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
        opa_d   = opa_q >> CHUNK;
        opb_d   = opb_q >> CHUNK;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          c_out_d     = slice_cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          ovf_d       = slice_cmsb ^ slice_cout;
`endif
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 8-bit/2-bit main instance plus two
// 16-bit instances (CHUNK=16 and CHUNK=1). Honours SEQ_CHUNK_ADDER_OVF_EN.
module tb_seq_chunk_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [7:0] x, y, s;

  logic        in_valid16, c_in16, sub16, out_ready16;
  logic [15:0] x16, y16;
  logic        in_ready_a, out_valid_a, c_out_a;
  logic        in_ready_b, out_valid_b, c_out_b;
  logic [15:0] s_a, s_b;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic        ovf, ovf_a, ovf_b;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .c_out(c_out)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_a),
    .x(x16), .y(y16), .c_in(c_in16), .sub(sub16),
    .out_valid(out_valid_a), .out_ready(out_ready16), .s(s_a),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf_a),
`endif
    .c_out(c_out_a)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_b),
    .x(x16), .y(y16), .c_in(c_in16), .sub(sub16),
    .out_valid(out_valid_b), .out_ready(out_ready16), .s(s_b),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf_b),
`endif
    .c_out(c_out_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Present one operation, wait for the result, check it, then consume it.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb, input logic [7:0] es,
                     input logic ec, input logic eovf);
    int lat;
    @(negedge clk);
    x = a; y = b; c_in = ci; sub = sb; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); y = 8'($urandom); c_in = ~ci; sub = ~sb;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_c_out"}, 32'(c_out), 32'(ec));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected x on ovf expectation");
`endif
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_back_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat, la, lb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; x16 = '0; y16 = '0; c_in16 = 1'b0; sub16 = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op8("add_0f_03", 8'h0F, 8'h03, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_ff_00_ci", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Backpressure: result held in DONE while new operands are offered.
    @(negedge clk);
    x = 8'h0F; y = 8'h03; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; x = 8'($urandom); y = 8'($urandom); sub = ~sub;
      @(posedge clk); #1;
      check($sformatf("bp_s_%0d", i), 32'(s), 32'h12);
      check($sformatf("bp_c_out_%0d", i), 32'(c_out), 32'd0);
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    op8("after_bp", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);

    // Reset in the middle of RUN.
    @(negedge clk);
    x = 8'h0F; y = 8'h03; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_s", 32'(s), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    op8("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // 16-bit instances: 0x8000 + 0x8000 with CHUNK=16 and CHUNK=1.
    @(negedge clk);
    x16 = 16'h8000; y16 = 16'h8000; c_in16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1; in_valid16 = 1'b0;
    lat = 0; la = -1; lb = -1;
    while (lat < 40 && (la < 0 || lb < 0)) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid_a && la < 0) la = lat;
      if (out_valid_b && lb < 0) lb = lat;
    end
    check("w16c16_latency", 32'(la), 32'd1);
    check("w16c1_latency", 32'(lb), 32'd16);
    check("w16c16_s", 32'(s_a), 32'h0000);
    check("w16c16_c_out", 32'(c_out_a), 32'd1);
    check("w16c1_s", 32'(s_b), 32'h0000);
    check("w16c1_c_out", 32'(c_out_b), 32'd1);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check("w16c16_ovf", 32'(ovf_a), 32'd1);
    check("w16c1_ovf", 32'(ovf_b), 32'd1);
`endif
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
    check("w16_release_a", 32'(in_ready_a), 32'd1);
    check("w16_release_b", 32'(in_ready_b), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
